prng_checker: RTL and testbench



---
 rtl/prng_pkg.sv | 32 +++
 rtl/prng_checker_popcount.sv | 23 ++
 rtl/prng_checker.sv | 208 ++++++++++++++++++++
 tb/tb_prng_checker.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared definitions for the LFSR pseudo-random generator and its checker:
// default polynomial and seed, the checker state encoding, and the single
// Galois step function both sides use so they can never drift apart.
package prng_pkg;

    // Widest LFSR the shared step function supports.
    localparam int PRNG_MAX_W = 64;

    // Default Galois feedback polynomial and generator seed.
    localparam logic [31:0] PRNG_POLY = 32'h80200003;
    localparam logic [31:0] PRNG_SEED = 32'hdeadbeef;

    // Checker synchronisation states.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prng_state_t;

    // One Galois LFSR step. Callers zero-extend their W-bit state and
    // polynomial to PRNG_MAX_W. Because the unused upper bits are zero, a
    // plain right shift equals {1'b0, x[W-1:1]} for any W up to PRNG_MAX_W.
    function automatic logic [PRNG_MAX_W-1:0] prng_step(
        input logic [PRNG_MAX_W-1:0] x,
        input logic [PRNG_MAX_W-1:0] poly
    );
        logic [PRNG_MAX_W-1:0] shifted;
        shifted = x >> 1;
        return x[0] ? (shifted ^ poly) : shifted;
    endfunction

endpackage

// File: rtl/prng_checker_popcount.sv
// Combinational population count of a W-bit word. The checker uses it to
// count the bits that differ between the received and predicted words.
// This module exists only when PRNG_CHECKER_BITERR_EN is defined.
`ifdef PRNG_CHECKER_BITERR_EN
module popcount #(
    parameter int W = 32
) (
    input  logic [W-1:0]         x,
    output logic [$clog2(W+1)-1:0] cnt
);

    localparam int CNTW = $clog2(W+1);

    // Add up the set bits of x.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CNTW'(x[i]);
        end
    end

endmodule
`endif

// File: rtl/prng_checker.sv
// Receive-side checker for an LFSR pseudo-random word stream.
//
// The checker seeds itself from the incoming stream, confirms the seed over
// LOCK_CNT correct predictions, and then runs as a flywheel: the local LFSR
// advances on every valid word without ever being reseeded, so a single
// corrupted word produces exactly one error. LOSS_CNT consecutive
// mispredictions while locked drop back to searching.
//
// Stream interface: val is a qualifier only. Each cycle with val=1 carries
// exactly one word on dat; there is no ready, the checker accepts every word.
// Cycles with val=0 leave all state untouched and deassert err and lost.
//
// Build option: define PRNG_CHECKER_BITERR_EN to make err_cnt count bit
// errors (popcount of dat ^ prediction) and to add the bit_err output.
module prng_checker
    import prng_pkg::*;
#(
    parameter int           W        = 32,
    parameter logic [W-1:0] POLY     = 32'h80200003,
    parameter int           LOCK_CNT = 4,
    parameter int           LOSS_CNT = 3,
    parameter int           CW       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   val,
    input  logic [W-1:0]           dat,
    output logic                   locked,
    output logic                   err,
    output logic                   err_sticky,
    output logic                   lost,
    output logic [CW-1:0]          err_cnt,
`ifdef PRNG_CHECKER_BITERR_EN
    output logic [$clog2(W+1)-1:0] bit_err,
`endif
    output logic [1:0]             state_dbg
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam int IW = $clog2(W + 1);

    prng_state_t   state, state_n;
    logic [W-1:0]  lfsr, lfsr_n;
    logic [W-1:0]  pred;
    logic [MW-1:0] match_cnt, match_n;
    logic [LW-1:0] miss_cnt, miss_n;
    logic          locked_n;
    logic          err_n;
    logic          lost_n;

    logic [IW-1:0] inc;
    logic [CW:0]   sum;
    logic [CW-1:0] sat;
    logic [CW-1:0] cnt_n;
    logic          sticky_n;

    // Next word the generator should produce given the current LFSR state.
    assign pred = W'(prng_step(PRNG_MAX_W'(lfsr), PRNG_MAX_W'(POLY)));

`ifdef PRNG_CHECKER_BITERR_EN
    logic [IW-1:0] pop;

    popcount #(
        .W (W)
    ) u_popcount (
        .x   (dat ^ pred),
        .cnt (pop)
    );

    assign inc = pop;
`else
    assign inc = IW'(1);
`endif

    assign state_dbg = state;

    // Synchronisation state machine: state register and per-word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            lfsr      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            lost      <= 1'b0;
        end else begin
            state     <= state_n;
            lfsr      <= lfsr_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            locked    <= locked_n;
            err       <= err_n;
            lost      <= lost_n;
        end
    end

    // Next-state decode. Only valid words move the machine; an all-zero word
    // is refused as a seed because the LFSR would stick at zero forever.
    always_comb begin
        state_n  = state;
        lfsr_n   = lfsr;
        match_n  = match_cnt;
        miss_n   = miss_cnt;
        locked_n = locked;
        err_n    = 1'b0;
        lost_n   = 1'b0;
        if (val) begin
            case (state)
                SEARCH: begin
                    if (dat != '0) begin
                        lfsr_n  = dat;
                        match_n = '0;
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (dat == '0) begin
                        // A nonzero LFSR never predicts zero, so this is a
                        // failed seed: go back and look for a fresh one.
                        lfsr_n  = '0;
                        match_n = '0;
                        state_n = SEARCH;
                    end else if (dat == pred) begin
                        lfsr_n = dat;
                        if (match_cnt == MW'(LOCK_CNT - 1)) begin
                            match_n  = '0;
                            miss_n   = '0;
                            locked_n = 1'b1;
                            state_n  = LOCKED;
                        end else begin
                            match_n = match_cnt + 1'b1;
                        end
                    end else begin
                        // Wrong guess: the received word becomes the new seed.
                        lfsr_n  = dat;
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: advance on prediction, never on received data.
                    lfsr_n = pred;
                    if (dat == pred) begin
                        miss_n = '0;
                    end else begin
                        err_n = 1'b1;
                        if (miss_cnt == LW'(LOSS_CNT - 1)) begin
                            miss_n   = '0;
                            locked_n = 1'b0;
                            lost_n   = 1'b1;
                            state_n  = SEARCH;
                        end else begin
                            miss_n = miss_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n  = SEARCH;
                    locked_n = 1'b0;
                end
            endcase
        end
    end

    // Saturating increment of the error counter.
    assign sum = {1'b0, err_cnt} + (CW+1)'(inc);
    assign sat = sum[CW] ? {CW{1'b1}} : sum[CW-1:0];

    // Counter/sticky update. A clear in the same cycle as an error wipes the
    // old history but keeps the new error.
    always_comb begin
        cnt_n    = err_cnt;
        sticky_n = err_sticky;
        if (clr) begin
            cnt_n    = '0;
            sticky_n = 1'b0;
        end
        if (err_n) begin
            sticky_n = 1'b1;
            cnt_n    = clr ? CW'(inc) : sat;
        end
    end

    // Error counter and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            err_cnt    <= cnt_n;
            err_sticky <= sticky_n;
        end
    end

`ifdef PRNG_CHECKER_BITERR_EN
    // Bit-error count of the current word, aligned with the err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_err <= '0;
        end else begin
            bit_err <= err_n ? pop : '0;
        end
    end
`endif

endmodule

// File: tb/tb_prng_checker.sv
// Self-checking bench for prng_checker. A generator model drives the stream;
// every driven cycle pushes the expected outputs into a scoreboard queue and
// a separate monitor pops and compares one cycle later.
// Define PRNG_CHECKER_BITERR_EN to exercise the bit-error build.
`timescale 1ns/1ps
module tb_prng_checker;
    import prng_pkg::*;

    localparam int W        = 32;
    localparam int CW       = 6;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int BW       = $clog2(W + 1);
    localparam logic [W-1:0] POLY = PRNG_POLY;
    localparam int CMAX     = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          val;
    logic [W-1:0]  dat;
    logic          locked;
    logic          err;
    logic          err_sticky;
    logic          lost;
    logic [CW-1:0] err_cnt;
    logic [1:0]    state_dbg;
    logic [BW-1:0] bit_err_obs;
`ifdef PRNG_CHECKER_BITERR_EN
    logic [BW-1:0] bit_err;
    assign bit_err_obs = bit_err;
`else
    assign bit_err_obs = '0;
`endif

    prng_checker #(
        .W        (W),
        .POLY     (POLY),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .CW       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .val        (val),
        .dat        (dat),
        .locked     (locked),
        .err        (err),
        .err_sticky (err_sticky),
        .lost       (lost),
        .err_cnt    (err_cnt),
`ifdef PRNG_CHECKER_BITERR_EN
        .bit_err    (bit_err),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        int            due;
        logic          locked;
        logic          err;
        logic          lost;
        logic          sticky;
        logic [CW-1:0] cnt;
        logic [BW-1:0] bits;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Stream-level view: mode 0 = hunting for a seed, 1 = confirming it,
    // 2 = tracking. m_last is the last word the checker accepted/predicted.
    int           m_mode;
    logic [W-1:0] m_last;
    int           m_good;
    int           m_bad;
    int           m_cnt;
    bit           m_sticky;
    logic [W-1:0] gen;

    function automatic logic [W-1:0] next_word(input logic [W-1:0] x);
        return (x >> 1) ^ ((x % 2 == 1) ? POLY : '0);
    endfunction

    task automatic model_reset();
        m_mode   = 0;
        m_last   = '0;
        m_good   = 0;
        m_bad    = 0;
        m_cnt    = 0;
        m_sticky = 0;
    endtask

    // Drive one cycle and record what the checker must show after it.
    task automatic drive(input bit v, input logic [W-1:0] d, input bit c);
        exp_t         e;
        logic [W-1:0] p;
        bit           e_err;
        bit           e_lost;
        int           amount;
        @(posedge clk);
        #1;
        val = v;
        dat = d;
        clr = c;
        e_err  = 0;
        e_lost = 0;
        p      = next_word(m_last);
        if (v) begin
            if (m_mode == 0) begin
                if (d != 0) begin
                    m_last = d;
                    m_good = 0;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (d == 0) begin
                    m_mode = 0;
                    m_good = 0;
                    m_last = '0;
                end else if (d == p) begin
                    m_last = d;
                    m_good++;
                    if (m_good == LOCK_CNT) begin
                        m_mode = 2;
                        m_bad  = 0;
                    end
                end else begin
                    m_last = d;
                    m_good = 0;
                end
            end else begin
                m_last = p;
                if (d == p) begin
                    m_bad = 0;
                end else begin
                    e_err = 1;
                    m_bad++;
                    if (m_bad == LOSS_CNT) begin
                        m_mode = 0;
                        m_bad  = 0;
                        e_lost = 1;
                    end
                end
            end
        end
`ifdef PRNG_CHECKER_BITERR_EN
        amount = $countones(d ^ p);
`else
        amount = 1;
`endif
        if (c) begin
            m_cnt    = 0;
            m_sticky = 0;
        end
        if (e_err) begin
            m_sticky = 1;
            m_cnt    = (m_cnt + amount > CMAX) ? CMAX : m_cnt + amount;
        end
        e.due    = cyc + 1;
        e.locked = (m_mode == 2);
        e.err    = e_err;
        e.lost   = e_lost;
        e.sticky = m_sticky;
        e.cnt    = CW'(m_cnt);
`ifdef PRNG_CHECKER_BITERR_EN
        e.bits   = e_err ? BW'(amount) : '0;
`else
        e.bits   = '0;
`endif
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL scoreboard_stale: entry due %0d not compared by cycle %0d", e.due, cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("outputs{locked,err,lost,sticky,cnt,bits}",
                    32'({locked, err, lost, err_sticky, err_cnt, bit_err_obs}),
                    32'({e.locked, e.err, e.lost, e.sticky, e.cnt, e.bits}));
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, gen, 1'b0);
            gen = next_word(gen);
        end
    endtask

    task automatic send_bad(input logic [W-1:0] mask, input bit c);
        drive(1'b1, gen ^ mask, c);
        gen = next_word(gen);
    endtask

    // Idle the stream and wait (bounded) for the scoreboard to empty.
    task automatic drain();
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [W-1:0] rand_mask();
        logic [W-1:0] m;
        m = $urandom();
        if (m == 0) m = 1;
        return m;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        val   = 1'b0;
        dat   = '0;
        clr   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_lost", 32'(lost), 32'd0);
        chk("reset_sticky", 32'(err_sticky), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        chk("reset_state", 32'(state_dbg), 32'(SEARCH));
        @(negedge clk);
        rst_n = 1'b1;

        // Clean stream from the default seed, locks on word 5; word 10 hit.
        gen = PRNG_SEED;
        send_clean(9);
        send_bad(32'h1, 1'b0);
        send_clean(4);
        drain();
        chk("single_err_cnt", 32'(err_cnt), 32'd1);
        chk("single_err_locked", 32'(locked), 32'd1);

        // Three consecutive bad words drop lock, then a clean relock.
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) send_bad(32'h1, 1'b0);
        send_clean(8);
        drain();
        chk("loss_err_cnt", 32'(err_cnt), 32'd3);
        chk("relock", 32'(locked), 32'd1);

        // Clean stream with random gaps; dat is garbage on idle cycles.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) send_clean(1);
            else drive(1'b0, $urandom(), 1'b0);
        end

        // Seven spaced errors, then clear together with a new error.
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            send_bad(32'h1, 1'b0);
            send_clean(1);
        end
        send_bad(32'h1, 1'b1);
        send_clean(2);
        drain();
        chk("clr_with_err_cnt", 32'(err_cnt), 32'd1);
        chk("clr_with_err_sticky", 32'(err_sticky), 32'd1);

        // Saturation of the error counter.
        for (int i = 0; i < 70; i++) begin
            send_bad(rand_mask(), 1'b0);
            send_clean(1);
        end
        drain();
        chk("saturated_err_cnt", 32'(err_cnt), 32'(CMAX));

        // Random mix of gaps, corruption and clears.
        for (int i = 0; i < 300; i++) begin
            int r;
            bit c;
            r = $urandom_range(0, 15);
            c = ($urandom_range(0, 15) == 0);
            if (r < 4) drive(1'b0, $urandom(), c);
            else if (r < 6) send_bad(rand_mask(), c);
            else begin
                drive(1'b1, gen, c);
                gen = next_word(gen);
            end
        end
        send_clean(8);

        // All-zero stream never locks.
        for (int i = 0; i < 30; i++) drive(1'b1, '0, 1'b0);
        drain();
        chk("zeros_unlocked", 32'(locked), 32'd0);
        send_clean(8);
        drain();

        // Asynchronous reset while locked.
        rst_n = 1'b0;
        #1;
        chk("async_reset_locked", 32'(locked), 32'd0);
        chk("async_reset_err_cnt", 32'(err_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_clean(4);
        drain();
        chk("resync_4_words", 32'(locked), 32'd0);
        send_clean(1);
        drain();
        chk("resync_5_words", 32'(locked), 32'd1);

        // Multi-bit corruption of one locked word.
        drive(1'b0, '0, 1'b1);
        send_bad(32'h0000000F, 1'b0);
        send_clean(2);
        drain();
`ifdef PRNG_CHECKER_BITERR_EN
        chk("nibble_err_cnt", 32'(err_cnt), 32'd4);
`else
        chk("nibble_err_cnt", 32'(err_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
